// File: rtl/seg7_pkg.sv
// Shared types and encodings for the seven-segment loopback decoder.
// The decoder honours the SEG7_DEC_BLANK_EN build option; nothing here depends on it.
package seg7_pkg;

    typedef logic [1:0] char_code_t;

    localparam char_code_t CH_D     = 2'b00;
    localparam char_code_t CH_E     = 2'b01;
    localparam char_code_t CH_1     = 2'b10;
    localparam char_code_t CH_BLANK = 2'b11;

    // Active-low segment patterns, bit 0 = segment a .. bit 6 = segment g
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_CHANGE = 2'd0,
        ST_COUNT  = 2'd1,
        ST_HELD   = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to character-code decoder.
// SEG7_DEC_BLANK_EN: when defined, the all-dark pattern decodes as a legal blank.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_i,
    output char_code_t code_o,
    output logic       legal_o
);

    always_comb begin
        code_o  = CH_BLANK;
        legal_o = 1'b0;
        case (seg_i)
            SEG_D: begin code_o = CH_D; legal_o = 1'b1; end
            SEG_E: begin code_o = CH_E; legal_o = 1'b1; end
            SEG_1: begin code_o = CH_1; legal_o = 1'b1; end
`ifdef SEG7_DEC_BLANK_EN
            SEG_BLANK: begin code_o = CH_BLANK; legal_o = 1'b1; end
`else
            SEG_BLANK: begin code_o = CH_BLANK; legal_o = 1'b0; end
`endif
            default: begin code_o = CH_BLANK; legal_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Debounced receive-side decoder for the multiplexed seven-segment drive.
// Build option SEG7_DEC_BLANK_EN (see seg7_pattern_decode) makes the blank pattern legal.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 3,
    parameter int STABLE_CYC = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [6:0]          seg_i,
    input  logic [NDIG-1:0]     dig_i,
    output logic [2*NDIG-1:0]   code_o,
    output logic [NDIG-1:0]     valid_o,
    output logic                err_o,
    output logic                frame_o
);

    localparam int            CW       = $clog2(STABLE_CYC);
    localparam logic [CW-1:0] CNT_TERM = CW'(STABLE_CYC - 1);

    logic [6:0]        seg_q;
    logic [NDIG-1:0]   dig_q;
    scan_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*NDIG-1:0] code_q, code_d;
    logic [NDIG-1:0]   valid_q, valid_d;
    logic [NDIG-1:0]   seen_q, seen_d, seen_nx;
    logic              err_q, err_d;
    logic              frame_q, frame_d;
    logic              same, accept;
    char_code_t        dec_code;
    logic              dec_legal;

    seg7_pattern_decode u_dec (
        .seg_i   (seg_q),
        .code_o  (dec_code),
        .legal_o (dec_legal)
    );

    assign same = (seg_i == seg_q) && (dig_i == dig_q);

    // The differing edge itself clears the count, so the first matching sample already counts as one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (!same) begin
            state_d = ST_CHANGE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_CHANGE: begin
                    state_d = ST_COUNT;
                    cnt_d   = CW'(1);
                end
                ST_COUNT: begin
                    if (cnt_q == CNT_TERM) begin
                        accept  = 1'b1;
                        state_d = ST_HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HELD: ;
                default: state_d = ST_CHANGE;
            endcase
        end
    end

    always_comb begin
        code_d  = code_q;
        valid_d = valid_q;
        err_d   = err_q;
        seen_d  = seen_q;
        seen_nx = seen_q | dig_q;
        frame_d = 1'b0;
        if (accept && (dig_q != '0)) begin
            if (!$onehot(dig_q)) begin
                err_d = 1'b1;
            end else begin
                for (int i = 0; i < NDIG; i++) begin
                    if (dig_q[i]) begin
                        if (dec_legal) begin
                            code_d[2*i +: 2] = dec_code;
                            valid_d[i]       = 1'b1;
                        end else begin
                            valid_d[i] = 1'b0;
                            err_d      = 1'b1;
                        end
                    end
                end
                if (&seen_nx) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end else begin
                    seen_d = seen_nx;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            seg_q   <= SEG_BLANK;
            dig_q   <= '0;
            state_q <= ST_CHANGE;
            cnt_q   <= '0;
            code_q  <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            err_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            seg_q   <= seg_i;
            dig_q   <= dig_i;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            err_q   <= err_d;
            frame_q <= frame_d;
        end
    end

    assign code_o  = code_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;
    assign frame_o = frame_q;

endmodule
